array_drain: RTL
================

Name: array_drain

Overview:
- Result-readout controller for the SIZE x SIZE systolic MAC array.
- Walks the array's `select` index across every accumulator and samples the array's combinational `d_out`.
- Emits each result as a valid/ready stream word tagged with its row/col, and holds the array compute enables off while draining.
- Sits between the array and the result writeback/DMA path.

Parameters:
- SIZE, 16, array dimension; SIZE*SIZE results per drain.
- DATA_W, 32, width of array `d_out` and of the stream data.
- COL_MAJOR, 0, traversal order: 0 = row-major (col fastest), 1 = column-major (row fastest).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a drain when idle.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the final word handshakes.
- array_hold  output  1  equals busy; upstream gates mult_en/acc_en/load_en low while set.
- select  output  SIZE*SIZE  index to the array, = row_q*SIZE+col_q, zero-extended.
- d_in  input  DATA_W  array `d_out`; combinational function of `select`.
- out_data  output  DATA_W  captured accumulator value.
- out_row  output  $clog2(SIZE)  row of out_data.
- out_col  output  $clog2(SIZE)  col of out_data.
- out_last  output  1  marks the final word of a drain.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from sink.

Behaviour:
- Reset values:
  - busy, done, out_valid, out_last = 0.
  - out_data, out_row, out_col = 0.
  - row_q = col_q = 0, so select = 0.
  - FSM = IDLE.
- FSM states are IDLE, RUN, FLUSH.
- IDLE:
  - start=1 -> RUN, with row_q=col_q=0.
  - Other inputs ignored.
- RUN, load rule:
  - Each cycle with (!out_valid || out_ready), the output register loads d_in, row_q, col_q; sets out_valid=1; sets out_last=(element is last).
  - The counter then advances.
  - Throughput is 1 word/clk with the sink always ready.
  - Latency: select presented cycle N -> word valid on out_* in cycle N+1.
- RUN, counter advance:
  - COL_MAJOR=0: col_q++; on col_q==SIZE-1, col_q wraps to 0 and row_q++.
  - COL_MAJOR=1: same with roles of row_q and col_q swapped.
- RUN -> FLUSH: when the last element (row_q=col_q=SIZE-1) loads. Counters reset to 0.
- FLUSH:
  - Holds until out_valid && out_ready, then clears out_valid and out_last.
  - Pulses done for one cycle and returns to IDLE.
- Backpressure:
  - While out_valid && !out_ready, out_data, out_row, out_col and out_last are stable.
  - Counters and select are frozen.
- Stream rule: out_valid never deasserts without a handshake. No word is dropped or duplicated.
- start while busy is ignored and has no effect on counters.
- busy and array_hold are high in RUN and FLUSH, low in IDLE.
- done and start coincident: the start is accepted only if the FSM is already IDLE. done is asserted on the FLUSH->IDLE edge, so a start in the done cycle is ignored.
- Reset mid-drain: all state returns to reset values next edge. A partially sent stream is abandoned with no out_last.
- SIZE=1: a single word with out_last=1. RUN goes directly to FLUSH.
- Width: select index arithmetic is done at $clog2(SIZE*SIZE)+1 bits and zero-extended; no overflow at SIZE*SIZE-1.

Decomposition:
- Shared package (matrix_pkg): localparam IDX_W=$clog2(SIZE*SIZE); enum drain_state_t {IDLE, RUN, FLUSH}.
- One natural sub-module: drain_addr_gen, holding the row/col counters, COL_MAJOR ordering, last-detect, and select computation, with an advance enable.
- Output register and FSM stay in array_drain.

Test Plan:
- SIZE=4, d_in=select*3 model, out_ready=1, start pulse:
  - 16 words on 16 consecutive cycles starting 2 cycles after start.
  - data 0,3,...,45 in row-major order.
  - out_last only on row=3,col=3.
  - done pulse one cycle after the final handshake.
- SIZE=4, COL_MAJOR=1: out_row/out_col sequence (0,0),(1,0),(2,0),(3,0),(0,1)...; data = (row*4+col)*3.
- Random out_ready at 30% duty:
  - all 16 words delivered exactly once, in order.
  - out_* stable across every stalled cycle.
  - array_hold stays high throughout.
- start re-pulsed at word 5 and again in the done cycle: both ignored; exactly 16 words; busy low after done.
- reset asserted at word 7 with out_valid=1 stalled: next cycle out_valid=0, busy=0, select=0. A fresh start produces a full 16-word drain from (0,0).
- SIZE=1: single word with out_last=1, done pulses; then a back-to-back start from IDLE yields a second single-word drain.

Source files
------------

// File: rtl/matrix_pkg.sv
// Types and width helpers shared by the systolic-array result readout path.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  // Row/col counter width; a 1x1 array still needs one bit to carry index 0.
  function automatic int rc_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int idx_width(input int size);
    return $clog2(size * size);
  endfunction

endpackage

// File: rtl/drain_addr_gen.sv
// Row/col walk over the accumulator grid, last-element detect and the flat
// select index presented to the array.
module drain_addr_gen
  import matrix_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int COL_MAJOR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      adv_i,
  output logic [rc_width(SIZE)-1:0] row_o,
  output logic [rc_width(SIZE)-1:0] col_o,
  output logic                      last_o,
  output logic [SIZE*SIZE-1:0]      select_o
);

  localparam int RC_W     = rc_width(SIZE);
  localparam int SEL_W    = idx_width(SIZE) + 1;
  localparam int SELECT_W = SIZE * SIZE;
  localparam logic [RC_W-1:0] MAX_RC = RC_W'(SIZE - 1);

  logic [RC_W-1:0]  row_q, row_d;
  logic [RC_W-1:0]  col_q, col_d;
  logic [SEL_W-1:0] idx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // The fast-moving counter wraps into the slow one; the slow one never wraps
  // because the last element clears both instead of advancing.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (COL_MAJOR == 0) begin
        if (col_q == MAX_RC) begin
          col_d = '0;
          row_d = row_q + RC_W'(1);
        end else begin
          col_d = col_q + RC_W'(1);
        end
      end else begin
        if (row_q == MAX_RC) begin
          row_d = '0;
          col_d = col_q + RC_W'(1);
        end else begin
          row_d = row_q + RC_W'(1);
        end
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  assign idx_s    = SEL_W'(row_q) * SEL_W'(SIZE) + SEL_W'(col_q);
  assign select_o = SELECT_W'(idx_s);
  assign last_o   = (row_q == MAX_RC) && (col_q == MAX_RC);
  assign row_o    = row_q;
  assign col_o    = col_q;

endmodule

// File: rtl/array_drain.sv
// Result-readout controller: walks every accumulator of the systolic array and
// streams each value out with its row/col tag while holding the array idle.
module array_drain
  import matrix_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int DATA_W    = 32,
  parameter int COL_MAJOR = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      array_hold,
  output logic [SIZE*SIZE-1:0]      select,
  input  logic [DATA_W-1:0]         d_in,
  output logic [DATA_W-1:0]         out_data,
  output logic [rc_width(SIZE)-1:0] out_row,
  output logic [rc_width(SIZE)-1:0] out_col,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int RC_W = rc_width(SIZE);

  drain_state_t      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [RC_W-1:0]   out_row_q, out_row_d;
  logic [RC_W-1:0]   out_col_q, out_col_d;

  logic              load_s, adv_s, clr_s, last_s;
  logic [RC_W-1:0]   row_s, col_s;

  drain_addr_gen #(
    .SIZE      (SIZE),
    .COL_MAJOR (COL_MAJOR)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (clr_s),
    .adv_i    (adv_s),
    .row_o    (row_s),
    .col_o    (col_s),
    .last_o   (last_s),
    .select_o (select)
  );

  assign load_s = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  // A start landing in the done cycle is refused so done always separates drains.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    adv_s       = 1'b0;
    clr_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = RUN;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (load_s) begin
          out_data_d  = d_in;
          out_row_d   = row_s;
          out_col_d   = col_s;
          out_valid_d = 1'b1;
          out_last_d  = last_s;
          if (last_s) begin
            clr_s   = 1'b1;
            state_d = FLUSH;
          end else begin
            adv_s   = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign busy       = busy_q;
  assign array_hold = busy_q;
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;

endmodule
